mastermind_scoreboard: RTL and testbench
========================================

Name: mastermind_scoreboard

Overview:
Downstream of the Mastermind datapath. Consumes each completed scoring result (red/white peg counts plus the guess just scored), counts guesses, and decides win or loss. Keeps a readable history of every guess in the current game and drives game-status and blink signals for the HEX display stage. The control FSM uses accept_guess to stop taking guesses once the game has ended.

Parameters:
MAX_GUESSES, 8, guesses allowed per game (2..15)
BLINK_DIV, 25000000, clk cycles per blink half-period in WON/LOST (>=2; benches use 4)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
result_valid  input  1  one-cycle pulse: red/white/guess valid this cycle
red  input  3  red peg count of scored guess
white  input  3  white peg count of scored guess
guess  input  12  scored guess, 4 x 3-bit symbols, symbol 1 in [2:0]
new_game  input  1  one-cycle pulse: start a fresh game
hist_sel  input  4  history entry index for readback (0 = first guess)
accept_guess  output  1  high while state is PLAY
game_state  output  2  0 = PLAY, 1 = WON, 2 = LOST (3 never driven)
guess_count  output  4  number of results recorded this game
last_red  output  3  red of most recent recorded result
last_white  output  3  white of most recent recorded result
hist_guess  output  12  guess stored at hist_sel
hist_red  output  3  red stored at hist_sel
hist_white  output  3  white stored at hist_sel
hist_valid  output  1  hist_sel < guess_count
blink  output  1  toggles every BLINK_DIV cycles in WON/LOST; 0 in PLAY
err  output  1  sticky: an invalid result was seen this game

Behaviour:
- Reset (async, resetn low): state PLAY; guess_count 0; last_red/last_white 0; all history entries 0; blink 0; blink counter 0; err 0. accept_guess is 1 immediately.
- The FSM has three states: PLAY, WON, LOST.
- In PLAY, a result_valid pulse is valid when red + white <= 4, with the sum computed 4 bits wide.
- On a valid result, at the next edge:
  - history[guess_count] <= {guess, red, white}
  - guess_count increments
  - last_red/last_white <= red/white
- State transition on the same edge, win having priority:
  - red == 4 -> WON
  - else guess_count + 1 == MAX_GUESSES -> LOST
  - else stay in PLAY.
- An invalid result (red + white > 4) in PLAY sets err. Nothing else changes and the result does not count as a guess.
- result_valid in WON or LOST is ignored entirely: no history write, no count change, no err.
- new_game pulse, in any state:
  - next edge: state PLAY, guess_count 0, last_red/last_white 0, err 0, blink 0, blink counter 0
  - history contents are not cleared; hist_valid masks them.
- new_game asserted in the same cycle as result_valid: new_game wins and the result is dropped.
- History readback is combinational from hist_sel and registered storage.
  - hist_sel >= guess_count, or >= MAX_GUESSES: hist_guess/hist_red/hist_white read 0 and hist_valid is 0.
- Write-to-read latency is 1 cycle: an entry written at edge N is readable after edge N.
- Blink:
  - In WON/LOST, a counter runs 0..BLINK_DIV-1 and toggles blink on wrap. The first toggle occurs BLINK_DIV cycles after entering the state.
  - In PLAY, the counter is held at 0 and blink is 0.
- guess_count never exceeds MAX_GUESSES. It saturates by construction, because LOST blocks further writes.
- accept_guess = (state == PLAY), decoded combinationally from the state register.
- No combinational path from result_valid to any output.

Test Plan:
- Win on guess 3 (reset, result_valid with red/white 1/1, then 2/0, then 4/0) -> guess_count 3, game_state 1, accept_guess 0; hist_sel=2 gives hist_red 4, hist_valid 1; hist_sel=3 gives hist_valid 0.
- Loss (MAX_GUESSES=8, eight results of red 1/white 0) -> LOST after the 8th; guess_count 8; a 9th pulse with red 4 leaves count 8 and game_state 2.
- Last-guess win: seven results of red 0, then the 8th with red 4 -> game_state 1 (WON), not LOST.
- Invalid result red 3/white 2 in PLAY -> err 1, guess_count unchanged, no history write. A following new_game clears err to 0.
- Simultaneous new_game and result_valid (red 4) in WON state -> state PLAY, guess_count 0, hist_valid 0 for every hist_sel.
- Blink with BLINK_DIV=4: after a win, blink toggles exactly every 4 cycles. Assert resetn low mid-count -> all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/mastermind_scoreboard_if.sv
// ---------------------------------------------------------------------------
// mastermind_scoreboard_if
//
// Purpose: bundles the signals between the Mastermind scoring datapath and
// control (the master) and the scoreboard (the slave).
//
// Handshake: result_valid is a one-cycle qualifier with no back-pressure.
// A result is taken on the rising edge where result_valid is high only when
// accept_guess is high in that cycle. Pulses while accept_guess is low are
// dropped. new_game is a one-cycle pulse that is always taken, and it takes
// priority over a result_valid in the same cycle.
//
// Master -> slave : result_valid, red, white, guess, new_game, hist_sel
// Slave -> master : accept_guess, game_state, guess_count, last_red,
//                   last_white, hist_guess, hist_red, hist_white,
//                   hist_valid, blink, err
// ---------------------------------------------------------------------------
interface mastermind_scoreboard_if;
  logic        result_valid;
  logic [2:0]  red;
  logic [2:0]  white;
  logic [11:0] guess;
  logic        new_game;
  logic [3:0]  hist_sel;

  logic        accept_guess;
  logic [1:0]  game_state;
  logic [3:0]  guess_count;
  logic [2:0]  last_red;
  logic [2:0]  last_white;
  logic [11:0] hist_guess;
  logic [2:0]  hist_red;
  logic [2:0]  hist_white;
  logic        hist_valid;
  logic        blink;
  logic        err;

  modport master (
    output result_valid, red, white, guess, new_game, hist_sel,
    input  accept_guess, game_state, guess_count, last_red, last_white,
           hist_guess, hist_red, hist_white, hist_valid, blink, err
  );

  modport slave (
    input  result_valid, red, white, guess, new_game, hist_sel,
    output accept_guess, game_state, guess_count, last_red, last_white,
           hist_guess, hist_red, hist_white, hist_valid, blink, err
  );
endinterface

// File: rtl/mastermind_scoreboard.sv
// ---------------------------------------------------------------------------
// mastermind_scoreboard
//
// Purpose: takes each scored guess from the Mastermind datapath, counts
// guesses, decides win or loss, and keeps a history of every guess in the
// current game. It also drives a blink signal for the HEX display while the
// game is over.
//
// Ports:
//   clk     - system clock, rising edge
//   resetn  - asynchronous active-low reset
//   bus     - mastermind_scoreboard_if.slave (see the interface for the
//             signal list and the result_valid/accept_guess handshake)
//
// Parameters:
//   MAX_GUESSES - guesses allowed per game (2..15)
//   BLINK_DIV   - clk cycles per blink half-period in WON/LOST (>= 2)
//
// game_state is the raw FSM state register (0 PLAY, 1 WON, 2 LOST), so
// checkers can observe the FSM directly.
// ---------------------------------------------------------------------------
module mastermind_scoreboard #(
  parameter int unsigned MAX_GUESSES = 8,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input logic                    clk,
  input logic                    resetn,
  mastermind_scoreboard_if.slave bus
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WON  = 2'd1,
    LOST = 2'd2
  } state_t;

  localparam int unsigned        CW      = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]      CNT_MAX = CW'(BLINK_DIV - 1);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [4:0]         MAX5    = 5'(MAX_GUESSES);

  // History entry layout: {guess[11:0], red[2:0], white[2:0]}
  localparam int unsigned        EW      = 18;

  state_t        state;
  logic [3:0]    count;
  logic [2:0]    lred;
  logic [2:0]    lwhite;
  logic [EW-1:0] hist_mem [MAX_GUESSES];
  logic [CW-1:0] blink_cnt;
  logic          blink_q;
  logic          err_q;

  // Sum is formed 4 bits wide so that e.g. 5 + 4 cannot wrap into range.
  logic [3:0]    peg_sum;
  logic          take_result;
  logic          good_result;
  logic          bad_result;
  logic          last_slot;

  assign peg_sum     = {1'b0, bus.red} + {1'b0, bus.white};
  assign take_result = bus.result_valid && (state == PLAY) && !bus.new_game;
  assign good_result = take_result && (peg_sum <= 4'd4);
  assign bad_result  = take_result && (peg_sum > 4'd4);
  assign last_slot   = (({1'b0, count} + 5'd1) == MAX5);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= PLAY;
      count     <= '0;
      lred      <= '0;
      lwhite    <= '0;
      blink_cnt <= '0;
      blink_q   <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < int'(MAX_GUESSES); i++) begin
        hist_mem[i] <= '0;
      end
    end else if (bus.new_game) begin
      // History is left in place; guess_count = 0 masks it on readback.
      state     <= PLAY;
      count     <= '0;
      lred      <= '0;
      lwhite    <= '0;
      blink_cnt <= '0;
      blink_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          blink_cnt <= '0;
          blink_q   <= 1'b0;
          if (good_result) begin
            for (int i = 0; i < int'(MAX_GUESSES); i++) begin
              if (count == 4'(i)) begin
                hist_mem[i] <= {bus.guess, bus.red, bus.white};
              end
            end
            count  <= count + 4'd1;
            lred   <= bus.red;
            lwhite <= bus.white;
            // A win on the final allowed guess is still a win.
            if (bus.red == 3'd4) begin
              state <= WON;
            end else if (last_slot) begin
              state <= LOST;
            end
          end
          if (bad_result) begin
            err_q <= 1'b1;
          end
        end
        WON, LOST: begin
          // Counter starts from 0 on entry, so the first toggle lands
          // exactly BLINK_DIV edges after the state change.
          if (blink_cnt == CNT_MAX) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
          end else begin
            blink_cnt <= blink_cnt + CNT_ONE;
          end
        end
        default: begin
          state <= PLAY;
        end
      endcase
    end
  end

  // Combinational history readback; entries beyond guess_count read as 0.
  logic          rd_valid;
  logic [EW-1:0] rd_entry;

  always_comb begin
    rd_valid = (bus.hist_sel < count) && ({1'b0, bus.hist_sel} < MAX5);
    rd_entry = '0;
    for (int i = 0; i < int'(MAX_GUESSES); i++) begin
      if (rd_valid && (bus.hist_sel == 4'(i))) begin
        rd_entry = hist_mem[i];
      end
    end
  end

  assign bus.accept_guess = (state == PLAY);
  assign bus.game_state   = state;
  assign bus.guess_count  = count;
  assign bus.last_red     = lred;
  assign bus.last_white   = lwhite;
  assign bus.hist_guess   = rd_entry[17:6];
  assign bus.hist_red     = rd_entry[5:3];
  assign bus.hist_white   = rd_entry[2:0];
  assign bus.hist_valid   = rd_valid;
  assign bus.blink        = blink_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_mastermind_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_mastermind_scoreboard
//
// Directed bench for mastermind_scoreboard with MAX_GUESSES = 8 and
// BLINK_DIV = 4. Expected values are written by hand from the game rules.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_mastermind_scoreboard;

  localparam int unsigned MAXG = 8;
  localparam int unsigned BDIV = 4;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  mastermind_scoreboard_if bus ();

  mastermind_scoreboard #(
    .MAX_GUESSES (MAXG),
    .BLINK_DIV   (BDIV)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point: one immediate assertion per check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_result(input logic [2:0] r, input logic [2:0] w, input logic [11:0] g);
    @(negedge clk);
    bus.result_valid = 1'b1;
    bus.red          = r;
    bus.white        = w;
    bus.guess        = g;
    @(posedge clk);
    #1;
    bus.result_valid = 1'b0;
    bus.red          = '0;
    bus.white        = '0;
    bus.guess        = '0;
  endtask

  task automatic pulse_new_game(input logic with_result, input logic [2:0] r);
    @(negedge clk);
    bus.new_game     = 1'b1;
    bus.result_valid = with_result;
    bus.red          = r;
    @(posedge clk);
    #1;
    bus.new_game     = 1'b0;
    bus.result_valid = 1'b0;
    bus.red          = '0;
  endtask

  task automatic read_hist(input logic [3:0] sel);
    bus.hist_sel = sel;
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    read_hist(4'd0);
    check({pfx, "_accept"}, 32'(bus.accept_guess), 32'd1);
    check({pfx, "_state"},  32'(bus.game_state),   32'd0);
    check({pfx, "_count"},  32'(bus.guess_count),  32'd0);
    check({pfx, "_lred"},   32'(bus.last_red),     32'd0);
    check({pfx, "_lwhite"}, 32'(bus.last_white),   32'd0);
    check({pfx, "_blink"},  32'(bus.blink),        32'd0);
    check({pfx, "_err"},    32'(bus.err),          32'd0);
    check({pfx, "_hvalid"}, 32'(bus.hist_valid),   32'd0);
    check({pfx, "_hguess"}, 32'(bus.hist_guess),   32'd0);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    resetn           = 1'b0;
    bus.result_valid = 1'b0;
    bus.red          = '0;
    bus.white        = '0;
    bus.guess        = '0;
    bus.new_game     = 1'b0;
    bus.hist_sel     = '0;

    // Reset state
    #12;
    check_reset_values("rst");
    @(negedge clk);
    resetn = 1'b1;

    // Win on guess 3
    send_result(3'd1, 3'd1, 12'o1234);
    check("w1_count", 32'(bus.guess_count), 32'd1);
    check("w1_state", 32'(bus.game_state),  32'd0);
    send_result(3'd2, 3'd0, 12'o5612);
    check("w2_count", 32'(bus.guess_count), 32'd2);
    check("w2_lred",  32'(bus.last_red),    32'd2);
    send_result(3'd4, 3'd0, 12'o7713);
    check("w3_count",  32'(bus.guess_count),  32'd3);
    check("w3_state",  32'(bus.game_state),   32'd1);
    check("w3_accept", 32'(bus.accept_guess), 32'd0);
    check("w3_lred",   32'(bus.last_red),     32'd4);
    check("w3_blink0", 32'(bus.blink),        32'd0);

    // Blink: toggles 4 edges after the win edge, then every 4 edges
    wait_edges(3);
    check("bl_e3", 32'(bus.blink), 32'd0);
    wait_edges(1);
    check("bl_e4", 32'(bus.blink), 32'd1);
    wait_edges(3);
    check("bl_e7", 32'(bus.blink), 32'd1);
    wait_edges(1);
    check("bl_e8", 32'(bus.blink), 32'd0);

    // History readback in WON
    read_hist(4'd2);
    check("h2_red",   32'(bus.hist_red),   32'd4);
    check("h2_white", 32'(bus.hist_white), 32'd0);
    check("h2_guess", 32'(bus.hist_guess), 32'o7713);
    check("h2_valid", 32'(bus.hist_valid), 32'd1);
    read_hist(4'd0);
    check("h0_red",   32'(bus.hist_red),   32'd1);
    check("h0_white", 32'(bus.hist_white), 32'd1);
    check("h0_guess", 32'(bus.hist_guess), 32'o1234);
    read_hist(4'd3);
    check("h3_valid", 32'(bus.hist_valid), 32'd0);
    check("h3_guess", 32'(bus.hist_guess), 32'd0);
    read_hist(4'd15);
    check("h15_valid", 32'(bus.hist_valid), 32'd0);

    // result_valid in WON is ignored
    send_result(3'd2, 3'd1, 12'o4444);
    check("won_ign_count", 32'(bus.guess_count), 32'd3);
    check("won_ign_lred",  32'(bus.last_red),    32'd4);
    check("won_ign_err",   32'(bus.err),         32'd0);

    // new_game with simultaneous result (red 4) in WON: new_game wins
    pulse_new_game(1'b1, 3'd4);
    check("ng_state",  32'(bus.game_state),   32'd0);
    check("ng_count",  32'(bus.guess_count),  32'd0);
    check("ng_accept", 32'(bus.accept_guess), 32'd1);
    check("ng_lred",   32'(bus.last_red),     32'd0);
    check("ng_blink",  32'(bus.blink),        32'd0);
    for (int i = 0; i < 16; i++) begin
      read_hist(4'(i));
      check($sformatf("ng_hvalid%0d", i), 32'(bus.hist_valid), 32'd0);
    end

    // Invalid results: 3+2 and 5+4 (the latter wraps to 1 in 3 bits)
    send_result(3'd3, 3'd2, 12'o1111);
    check("inv1_err",   32'(bus.err),         32'd1);
    check("inv1_count", 32'(bus.guess_count), 32'd0);
    check("inv1_lred",  32'(bus.last_red),    32'd0);
    read_hist(4'd0);
    check("inv1_hvalid", 32'(bus.hist_valid), 32'd0);
    send_result(3'd5, 3'd4, 12'o2222);
    check("inv2_count", 32'(bus.guess_count), 32'd0);
    check("inv2_state", 32'(bus.game_state),  32'd0);
    // Boundary sum of exactly 4 is valid; err stays sticky
    send_result(3'd2, 3'd2, 12'o3333);
    check("sum4_count", 32'(bus.guess_count), 32'd1);
    check("sum4_err",   32'(bus.err),         32'd1);
    read_hist(4'd0);
    check("sum4_hred",   32'(bus.hist_red),   32'd2);
    check("sum4_hwhite", 32'(bus.hist_white), 32'd2);
    check("sum4_hguess", 32'(bus.hist_guess), 32'o3333);
    pulse_new_game(1'b0, 3'd0);
    check("ngerr_err",   32'(bus.err),         32'd0);
    check("ngerr_count", 32'(bus.guess_count), 32'd0);

    // Loss after eight results of red 1
    for (int i = 0; i < 7; i++) begin
      send_result(3'd1, 3'd0, 12'(i));
    end
    check("l7_count", 32'(bus.guess_count), 32'd7);
    check("l7_state", 32'(bus.game_state),  32'd0);
    send_result(3'd1, 3'd0, 12'o0707);
    check("l8_count",  32'(bus.guess_count),  32'd8);
    check("l8_state",  32'(bus.game_state),   32'd2);
    check("l8_accept", 32'(bus.accept_guess), 32'd0);
    send_result(3'd4, 3'd0, 12'o7777);
    check("l9_count", 32'(bus.guess_count), 32'd8);
    check("l9_state", 32'(bus.game_state),  32'd2);
    read_hist(4'd7);
    check("l_h7_valid", 32'(bus.hist_valid), 32'd1);
    check("l_h7_guess", 32'(bus.hist_guess), 32'o0707);
    read_hist(4'd8);
    check("l_h8_valid", 32'(bus.hist_valid), 32'd0);

    // Last-guess win: seven of red 0, then red 4
    pulse_new_game(1'b0, 3'd0);
    for (int i = 0; i < 7; i++) begin
      send_result(3'd0, 3'd1, 12'(i + 16));
    end
    send_result(3'd4, 3'd0, 12'o4321);
    check("lg_state", 32'(bus.game_state),  32'd1);
    check("lg_count", 32'(bus.guess_count), 32'd8);

    // Async reset mid blink count (blink high, counter at 1)
    wait_edges(5);
    check("pre_rst_blink", 32'(bus.blink), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values("arst");
    @(negedge clk);
    resetn = 1'b1;
    wait_edges(2);
    check("post_rst_count", 32'(bus.guess_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
